// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit counter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: steps up or down when its carry-in is set and reports
// carry/borrow out when it rolls over 9->0 or 0->9.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       step_i,
    input  logic       dir_i,     // 0 = up, 1 = down
    output logic [3:0] digit_o,
    output logic       cout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (step_i) begin
            if (!dir_i) begin
                if (digit_i == BCD_MAX) begin
                    digit_o = BCD_ZERO;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == BCD_ZERO) begin
                    digit_o = BCD_MAX;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with clear, validated parallel load and
// wrap/saturate behaviour at the ends of the range.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   display,
    output logic                  carry,
    output logic                  borrow,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    display_q, display_d, stepped;
    logic [DIGITS:0] chain;
    logic            carry_q, carry_d;
    logic            borrow_q, borrow_d;
    logic            load_err_q, load_err_d;
    logic            step, load_ok;

    assign step     = inc ^ dec;
    assign chain[0] = step;

    // Carry/borrow ripples through every digit in the same cycle.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_i (display_q[4*g +: 4]),
            .step_i  (chain[g]),
            .dir_i   (dec),
            .digit_o (stepped[4*g +: 4]),
            .cout_o  (chain[g+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(load_value[4*i +: 4])) load_ok = 1'b0;
        end
    end

    // A ripple out of the top digit means the step crossed an end of the range.
    always_comb begin
        display_d  = display_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            display_d = '0;
        end else if (load) begin
            if (load_ok) display_d = load_value;
            else         load_err_d = 1'b1;
        end else if (step) begin
            if (!chain[DIGITS]) begin
                display_d = stepped;
            end else if (WRAP) begin
                display_d = stepped;
                carry_d   = inc;
                borrow_d  = dec;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_q  <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            display_q  <= display_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign display  = display_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;
    assign at_max   = (display_q == {DIGITS{BCD_MAX}});
    assign at_zero  = (display_q == '0);

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Parametrised multi-digit BCD up/down counter with synchronous clear, parallel load, and wrap or saturate mode. It replaces the count-to-display conversion path: each enable pulse steps a packed BCD value held in registers. The value feeds the seven-segment display drivers directly. Digit-wise carry and borrow propagate within a single cycle, so the display never shows a non-BCD code.

## Interface
- DIGITS, 4: number of BCD digits (1–8); value width is 4*DIGITS.
- WRAP, 1: 1 = wrap at the ends (max→0, 0→max); 0 = saturate at the ends.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load of load_value.
- load_value  in  4*DIGITS  packed BCD load value; digit 0 is in [3:0].
- inc  in  1  count-up enable, one step per cycle.
- dec  in  1  count-down enable, one step per cycle.
- display  out  4*DIGITS  registered packed BCD count.
- carry  out  1  one-cycle pulse when an increment wraps from all-9s to 0.
- borrow  out  1  one-cycle pulse when a decrement wraps from 0 to all-9s.
- at_max  out  1  display == all 9s.
- at_zero  out  1  display == 0.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset (async, active-high): display=0, carry=0, borrow=0, load_err=0. Consequently at_zero=1, at_max=0.
- Per-cycle priority: clear > load > (inc XOR dec). Lower-priority requests in the same cycle are dropped.
- clear: display←0. No pulse outputs.
- load: every nibble of load_value is checked for ≤9.
  - All valid: display←load_value.
  - Any nibble 10–15: display holds, load_err pulses.
- inc=1, dec=0: digit 0 +1.
  - A digit at 9 becomes 0 and carries into the next digit; the chain ripples through all DIGITS in one cycle.
  - All digits at 9:
    - WRAP=1: display←0, carry pulses.
    - WRAP=0: display holds, no carry.
- dec=1, inc=0: digit 0 −1.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0:
    - WRAP=1: display←all 9s, borrow pulses.
    - WRAP=0: display holds, no borrow.
- inc=dec=1, or both 0: display holds.
- at_max and at_zero are combinational decodes of the display register, not extra flops.
- Digit arithmetic is 4-bit; no intermediate value above 9 is ever stored.

## Timing
- One-cycle latency: a request sampled at edge N appears on display after edge N.
- carry, borrow and load_err are registered and coincide with that same display update. They are high for exactly one cycle and clear on the following edge unless re-triggered.
- Back-to-back inc every cycle advances by 1 each cycle with no bubbles.
- Reset asserted mid-count forces all outputs to their reset values immediately, independent of clk. Counting resumes on the first edge after deassertion.
- Worst-case combinational path is the DIGITS-long carry/borrow ripple. DIGITS=8 must close timing at the system clock.

## Structure
- Package bcd_pkg:
  - constants BCD_MAX=4'd9 and BCD_ZERO=4'd0;
  - function is_bcd(nibble), used for load validation.
- Sub-module bcd_digit: one 4-bit digit with step, dir, cin→cout logic.
  - bcd_counter instantiates DIGITS of them in a generate loop.
  - bcd_counter owns the priority logic, the wrap/saturate decision and the pulse registers.

## Test plan
- Reset with DIGITS=4 → display=16'h0000, at_zero=1, at_max=0, all pulses 0. Assert reset mid-count at 16'h0456 → display=16'h0000 without a clock edge.
- load 16'h0999, then one inc → display=16'h1000 on the next cycle, carry=0. Then one dec → 16'h0999.
- WRAP=1: load 16'h9999 + inc → 16'h0000, carry=1 for one cycle. From 16'h0000, dec → 16'h9999, borrow=1 for one cycle.
- WRAP=0: at 16'h9999, 3× inc → display stays 16'h9999, carry=0, at_max=1. At 16'h0000, dec → stays, borrow=0.
- load 16'h12A4 → display unchanged, load_err=1 for one cycle. clear+load+inc in the same cycle → display=16'h0000.
- inc=dec=1 at 16'h0042 → hold. 10 consecutive inc from 16'h0095 → 16'h0105; every intermediate value is valid BCD (checker).
